fetch_queue: RTL and testbench

Parametrised fetch stage with prefetch buffering. It generates sequential PCs and issues instruction-memory requests through a valid/ready handshake, tolerating multiple in-flight reads. Returned instructions are buffered in a DEPTH-entry queue and presented to decode, which pops them with a ready signal. Branch and jump redirects from execute flush the queue and discard stale in-flight responses; this replaces the single PC register with stall/flush in front of the fetch/decode pipeline register.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fq_fifo.sv | 77 +++++++
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;
   localparam int XLEN_DEFAULT = 32;
   // Decode inserts this when it squashes a slot after a redirect.
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [31:0]             instr;
   } fetch_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with clear; head is read straight from storage, push on full succeeds only with a pop.
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_dat = mem_q[rd_ptr_q];
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage is reset so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: credit-limited sequential imem requests feeding a DEPTH-entry decode queue; redirects flush and drop stale responses.
// Response-to-decode is one registered stage; FETCH_QUEUE_BYPASS_EN forwards responses into an empty queue combinationally.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEFAULT,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [31:0]     dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_pcplus4
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = XLEN + 32;
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            active_q, active_d;

   logic            accept, rsp_ok, rsp_keep, byp_vld;
   logic            q_push, q_pop, q_empty, q_full;
   logic [CW-1:0]   q_count;
   logic [EW-1:0]   q_head;
   logic            pc_empty, pc_full;
   logic [CW-1:0]   pc_count;
   logic [XLEN-1:0] pc_head;
   logic [CW:0]     credit_used;

   // Every issued request owns a queue slot until it is popped, so responses never overflow.
   assign credit_used    = {1'b0, q_count} + {1'b0, outstanding_q};
   assign imem_req_valid = active_q & ~redirect_valid & ~pc_full & (credit_used < CREDIT_MAX);
   assign imem_addr      = fetch_pc_q;
   assign accept         = imem_req_valid & imem_req_ready;

   assign rsp_ok   = imem_rsp_valid & (outstanding_q != '0);
   assign rsp_keep = rsp_ok & ~redirect_valid & (drop_q == '0) & ~pc_empty;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp_vld     = rsp_keep & q_empty;
   assign dec_valid   = ~redirect_valid & (~q_empty | byp_vld);
   assign dec_instr   = byp_vld ? imem_rdata : q_head[31:0];
   assign dec_pc      = byp_vld ? pc_head : q_head[EW-1 -: XLEN];
`else
   assign byp_vld     = 1'b0;
   assign dec_valid   = ~redirect_valid & ~q_empty;
   assign dec_instr   = q_head[31:0];
   assign dec_pc      = q_head[EW-1 -: XLEN];
`endif
   assign dec_pcplus4 = dec_pc + XLEN'(4);

   assign q_pop  = dec_valid & dec_ready & ~byp_vld;
   assign q_push = rsp_keep & ~(byp_vld & dec_ready);

   fq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (redirect_valid),
      .push     (q_push),
      .push_dat ({pc_head, imem_rdata}),
      .pop      (q_pop),
      .head_dat (q_head),
      .full     (q_full),
      .empty    (q_empty),
      .count    (q_count)
   );

   fq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (redirect_valid),
      .push     (accept),
      .push_dat (fetch_pc_q),
      .pop      (rsp_keep),
      .head_dat (pc_head),
      .full     (pc_full),
      .empty    (pc_empty),
      .count    (pc_count)
   );

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      active_d      = 1'b1;
      case ({accept, rsp_ok})
         2'b10:   outstanding_d = outstanding_q + CW'(1);
         2'b01:   outstanding_d = outstanding_q - CW'(1);
         default: outstanding_d = outstanding_q;
      endcase
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         // No request issues this cycle, so this is what is still owed after this cycle's response.
         drop_d     = outstanding_d;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         active_q      <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         active_q      <= active_d;
      end
   end

   // Live PCs plus responses still to be dropped always account for every outstanding read.
   a_pc_tracking: assert property (@(posedge clk) disable iff (!rst_n)
      (pc_count + drop_q) == outstanding_q);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(q_full && q_push && !q_pop));
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_pcplus4;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   int checks = 0;
   int failures = 0;
   int lat = 1;
   int tcount = 0;

   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          acc_tick[$];
   logic [31:0] acc_addr[$];
   int          pop_tick[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_instr[$];
   logic [31:0] pop_pc4[$];

   fetch_queue dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_pcplus4    (dec_pcplus4)
   );

   always #5 clk = ~clk;

   task automatic clear_logs();
      acc_tick.delete();
      acc_addr.delete();
      pop_tick.delete();
      pop_pc.delete();
      pop_instr.delete();
      pop_pc4.delete();
   endtask

   // One clock: log handshakes mid-cycle, then advance the memory model (instruction word = ~address).
   task automatic tick();
      logic        acc;
      logic        rsp;
      logic [31:0] a;
      #2;
      acc = imem_req_valid & imem_req_ready;
      a   = imem_addr;
      rsp = imem_rsp_valid;
      if (acc) begin
         acc_tick.push_back(tcount);
         acc_addr.push_back(a);
      end
      if (dec_valid && dec_ready) begin
         pop_tick.push_back(tcount);
         pop_pc.push_back(dec_pc);
         pop_instr.push_back(dec_instr);
         pop_pc4.push_back(dec_pcplus4);
      end
      @(posedge clk);
      #1;
      tcount++;
      if (rsp && pend_addr.size() > 0) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (acc) begin
         pend_addr.push_back(a);
         pend_due.push_back(tcount + lat - 1);
      end
      if (pend_addr.size() > 0 && pend_due[0] <= tcount) begin
         imem_rsp_valid = 1'b1;
         imem_rdata     = ~pend_addr[0];
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rdata     = '0;
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec_ready      = 1'b1;
      pend_addr.delete();
      pend_due.delete();
      clear_logs();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      tcount = 0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      dec_ready      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rst_dec_valid got %b exp 0", dec_valid); end
      checks++; if (dec_instr !== 32'h0) begin failures++; $display("FAIL rst_dec_instr got %h exp 00000000", dec_instr); end
      checks++; if (dec_pc !== 32'h0) begin failures++; $display("FAIL rst_dec_pc got %h exp 00000000", dec_pc); end
      checks++; if (dec_pcplus4 !== 32'h4) begin failures++; $display("FAIL rst_dec_pcplus4 got %h exp 00000004", dec_pcplus4); end
      rst_n  = 1'b1;
      tcount = 0;
      tick();
      checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_req_addr got %h exp 00000000", imem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      lat = 1;
      do_reset();
      repeat (8) tick();
      checks++;
      if (acc_addr.size() < 3 || pop_pc.size() < 3) begin
         failures++; $display("FAIL stream_counts got acc=%0d pop=%0d exp >=3", acc_addr.size(), pop_pc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            e = 32'(4 * i);
            checks++; if (acc_addr[i] !== e) begin failures++; $display("FAIL stream_acc_addr[%0d] got %h exp %h", i, acc_addr[i], e); end
            checks++; if (acc_tick[i] !== 1 + i) begin failures++; $display("FAIL stream_acc_tick[%0d] got %0d exp %0d", i, acc_tick[i], 1 + i); end
            checks++; if (pop_pc[i] !== e) begin failures++; $display("FAIL stream_pop_pc[%0d] got %h exp %h", i, pop_pc[i], e); end
            checks++; if (pop_instr[i] !== ~e) begin failures++; $display("FAIL stream_pop_instr[%0d] got %h exp %h", i, pop_instr[i], ~e); end
            checks++; if (pop_pc4[i] !== e + 32'h4) begin failures++; $display("FAIL stream_pop_pc4[%0d] got %h exp %h", i, pop_pc4[i], e + 32'h4); end
            checks++; if (pop_tick[i] !== 3 - BYP + i) begin failures++; $display("FAIL stream_pop_tick[%0d] got %0d exp %0d", i, pop_tick[i], 3 - BYP + i); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      lat = 1;
      do_reset();
      dec_ready = 1'b0;
      repeat (10) tick();
      checks++; if (acc_addr.size() !== 4) begin failures++; $display("FAIL bp_issue_count got %0d exp 4", acc_addr.size()); end
      for (int i = 0; i < acc_addr.size() && i < 4; i++) begin
         e = 32'(4 * i);
         checks++; if (acc_addr[i] !== e) begin failures++; $display("FAIL bp_acc_addr[%0d] got %h exp %h", i, acc_addr[i], e); end
      end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin failures++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=00000000", dec_valid, dec_pc); end
      clear_logs();
      dec_ready = 1'b1;
      repeat (6) tick();
      checks++;
      if (pop_pc.size() < 4 || acc_addr.size() < 1) begin
         failures++; $display("FAIL bp_release_counts got pop=%0d acc=%0d exp pop>=4 acc>=1", pop_pc.size(), acc_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = 32'(4 * i);
            checks++; if (pop_pc[i] !== e) begin failures++; $display("FAIL bp_pop_pc[%0d] got %h exp %h", i, pop_pc[i], e); end
            checks++; if (pop_tick[i] !== pop_tick[0] + i) begin failures++; $display("FAIL bp_pop_tick[%0d] got %0d exp %0d", i, pop_tick[i], pop_tick[0] + i); end
         end
         checks++; if (acc_addr[0] !== 32'h10) begin failures++; $display("FAIL bp_resume_addr got %h exp 00000010", acc_addr[0]); end
      end
   endtask

   task automatic test_async_reset();
      lat = 1;
      do_reset();
      dec_ready = 1'b0;
      repeat (6) tick();
      checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got %b exp 1", dec_valid); end
      rst_n = 1'b0;
      #2;
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL areset_dec_valid got %b exp 0", dec_valid); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL areset_req_valid got %b exp 0", imem_req_valid); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL areset_addr got %h exp 00000000", imem_addr); end
      checks++; if (dec_pcplus4 !== 32'h4) begin failures++; $display("FAIL areset_pcplus4 got %h exp 00000004", dec_pcplus4); end
   endtask

   task automatic test_redirect_drop();
      lat = 3;
      do_reset();
      repeat (3) tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rd_req_in_redirect got %b exp 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rd_target_req got v=%b a=%h exp v=1 a=00000100", imem_req_valid, imem_addr); end
      repeat (8) tick();
      checks++;
      if (acc_addr.size() < 4 || pop_pc.size() < 2) begin
         failures++; $display("FAIL rd_counts got acc=%0d pop=%0d exp acc>=4 pop>=2", acc_addr.size(), pop_pc.size());
      end else begin
         checks++; if (acc_addr[2] !== 32'h100 || acc_tick[2] !== 4) begin failures++; $display("FAIL rd_acc got a=%h t=%0d exp a=00000100 t=4", acc_addr[2], acc_tick[2]); end
         checks++; if (pop_pc[0] !== 32'h100) begin failures++; $display("FAIL rd_first_pop_pc got %h exp 00000100", pop_pc[0]); end
         checks++; if (pop_tick[0] !== 8 - BYP) begin failures++; $display("FAIL rd_first_pop_tick got %0d exp %0d", pop_tick[0], 8 - BYP); end
         checks++; if (pop_instr[0] !== ~32'h100) begin failures++; $display("FAIL rd_first_pop_instr got %h exp %h", pop_instr[0], ~32'h100); end
         checks++; if (pop_pc[1] !== 32'h104) begin failures++; $display("FAIL rd_second_pop_pc got %h exp 00000104", pop_pc[1]); end
      end
   endtask

   task automatic test_redirect_same_cycle();
      lat = 1;
      do_reset();
      repeat (5) tick();
      checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL sc_pre_valid got %b exp 1", dec_valid); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL sc_forced_invalid got %b exp 0", dec_valid); end
      clear_logs();
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL sc_queue_empty got %b exp 0", dec_valid); end
      checks++; if (imem_addr !== 32'h200 || imem_req_valid !== 1'b1) begin failures++; $display("FAIL sc_target_req got v=%b a=%h exp v=1 a=00000200", imem_req_valid, imem_addr); end
      repeat (4) tick();
      checks++;
      if (pop_pc.size() < 1) begin
         failures++; $display("FAIL sc_pop_count got 0 exp >=1");
      end else begin
         checks++; if (pop_pc[0] !== 32'h200) begin failures++; $display("FAIL sc_first_pop_pc got %h exp 00000200", pop_pc[0]); end
      end
   endtask

   task automatic test_ready_toggle();
      logic [31:0] e;
      lat = 1;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         imem_req_ready = (i % 2 == 0);
         tick();
      end
      imem_req_ready = 1'b1;
      checks++; if (acc_addr.size() !== 9) begin failures++; $display("FAIL tg_acc_count got %0d exp 9", acc_addr.size()); end
      for (int i = 0; i < acc_addr.size(); i++) begin
         e = 32'(4 * i);
         checks++; if (acc_addr[i] !== e) begin failures++; $display("FAIL tg_acc_addr[%0d] got %h exp %h", i, acc_addr[i], e); end
      end
      checks++; if (pop_pc.size() < 8) begin failures++; $display("FAIL tg_pop_count got %0d exp >=8", pop_pc.size()); end
      for (int i = 0; i < pop_pc.size(); i++) begin
         e = 32'(4 * i);
         checks++; if (pop_pc[i] !== e) begin failures++; $display("FAIL tg_pop_pc[%0d] got %h exp %h", i, pop_pc[i], e); end
      end
   endtask

   task automatic test_wrap();
      lat = 1;
      do_reset();
      repeat (2) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      clear_logs();
      repeat (6) tick();
      checks++;
      if (acc_addr.size() < 2 || pop_pc.size() < 2) begin
         failures++; $display("FAIL wrap_counts got acc=%0d pop=%0d exp >=2", acc_addr.size(), pop_pc.size());
      end else begin
         checks++; if (acc_addr[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_acc0 got %h exp fffffffc", acc_addr[0]); end
         checks++; if (acc_addr[1] !== 32'h0) begin failures++; $display("FAIL wrap_acc1 got %h exp 00000000", acc_addr[1]); end
         checks++; if (pop_pc[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pop_pc0 got %h exp fffffffc", pop_pc[0]); end
         checks++; if (pop_pc4[0] !== 32'h0) begin failures++; $display("FAIL wrap_pop_pc4_0 got %h exp 00000000", pop_pc4[0]); end
         checks++; if (pop_pc[1] !== 32'h0) begin failures++; $display("FAIL wrap_pop_pc1 got %h exp 00000000", pop_pc[1]); end
         checks++; if (pop_pc4[1] !== 32'h4) begin failures++; $display("FAIL wrap_pop_pc4_1 got %h exp 00000004", pop_pc4[1]); end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec_ready      = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_async_reset();
      test_redirect_drop();
      test_redirect_same_cycle();
      test_ready_toggle();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
